call_ret_ctrl: RTL

Call/return sequencer that drives the CPU's 16-entry, 11-bit hardware return stack (push/pop/stack_in, top-of-stack read back). Sits between the instruction decoder, the PC register and the stack. It turns CALL, RETURN, RETFIE and interrupt entry into correctly timed push/pop pulses and PC loads. It also tracks stack depth, flags overflow and underflow, and owns the global interrupt enable.

---
 rtl/call_ret_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/call_ret_ctrl.sv
// Call/return sequencer: turns CALL/RETURN/RETFIE/interrupt entry into timed
// push/pop strobes and PC loads, tracks stack depth and owns the global interrupt enable.
module call_ret_ctrl #(
    parameter int             ADDR_W     = 11,
    parameter int             DEPTH      = 16,
    parameter logic [10:0]    INT_VECTOR = 11'h004,
    localparam int            DW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              retfie_req,
    input  logic              irq,
    input  logic              gie_set,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic [ADDR_W-1:0] call_target,
    input  logic [ADDR_W-1:0] stack_top,
    output logic              push,
    output logic              pop,
    output logic [ADDR_W-1:0] stack_in,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ack,
    output logic              busy,
    output logic              gie,
    output logic [DW-1:0]     depth,
    output logic              overflow,
    output logic              underflow
);

    // state       | meaning
    // IDLE        | waiting; requests sampled here only
    // PUSH_CALL   | push pc_cur+1, jump to call_target, ack
    // PUSH_INT    | push pc_cur, jump to INT_VECTOR, no ack
    // POP_RET     | pop, jump to stack_top, ack
    // POP_RETFIE  | pop, jump to stack_top, ack, re-enable gie on exit
    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_CALL,
        S_PUSH_INT,
        S_POP_RET,
        S_POP_RETFIE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ret_addr;
    logic [ADDR_W-1:0]   r_dest;
    logic                r_gie;
    logic [DW-1:0]       r_depth;
    logic                r_overflow;
    logic                r_underflow;
    logic                w_push;
    logic                w_pop;
    logic                w_take_int;

    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    always_comb begin
        w_next_state = r_state;
        w_take_int   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (irq && r_gie) begin
                    w_next_state = S_PUSH_INT;
                    w_take_int   = 1'b1;
                end else if (call_req) begin
                    w_next_state = S_PUSH_CALL;
                end else if (retfie_req) begin
                    w_next_state = S_POP_RETFIE;
                end else if (ret_req) begin
                    w_next_state = S_POP_RET;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Return address and destination are captured on the accepting edge so the
    // strobe cycle does not depend on the request inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ret_addr <= '0;
            r_dest     <= '0;
        end else if (w_next_state == S_PUSH_INT && r_state == S_IDLE) begin
            r_ret_addr <= pc_cur;
            r_dest     <= INT_VECTOR[ADDR_W-1:0];
        end else if (w_next_state == S_PUSH_CALL && r_state == S_IDLE) begin
            r_ret_addr <= pc_cur + ADDR_W'(1);
            r_dest     <= call_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gie <= 1'b0;
        end else if (w_take_int) begin
            r_gie <= 1'b0;
        end else if (gie_set || r_state == S_POP_RETFIE) begin
            r_gie <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_push) begin
            if (r_depth < FULL) r_depth <= r_depth + DW'(1);
            else                r_overflow <= 1'b1;
        end else if (w_pop) begin
            if (r_depth != '0) r_depth <= r_depth - DW'(1);
            else               r_underflow <= 1'b1;
        end
    end

    always_comb begin
        w_push   = (r_state == S_PUSH_CALL) || (r_state == S_PUSH_INT);
        w_pop    = (r_state == S_POP_RET)   || (r_state == S_POP_RETFIE);
        push     = w_push;
        pop      = w_pop;
        pc_load  = w_push || w_pop;
        ack      = (r_state == S_PUSH_CALL) || w_pop;
        busy     = (r_state != S_IDLE);
        stack_in = w_push ? r_ret_addr : '0;
        pc_next  = '0;
        if (w_push)     pc_next = r_dest;
        else if (w_pop) pc_next = stack_top;
    end

    assign gie       = r_gie;
    assign depth     = r_depth;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
